// File: rtl/mult_share_arbiter.sv
// Round-robin owner arbitration in front of one pipelined signed fixed-point multiplier.
// The owner issues a burst of operand pairs; results come back tagged one-hot after LATENCY cycles.
module mult_share_arbiter #(
  parameter int unsigned N_REQ      = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              op_valid,
  input  logic [N_REQ-1:0]              op_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   op_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]   op_b,
  output logic [N_REQ-1:0]              grant,
  output logic [N_REQ-1:0]              res_valid,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic                          busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PW    = 2 * DATA_WIDTH;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [N_REQ-1:0]        r_grant, w_grant_nxt;
  logic [IDX_W-1:0]        r_last_owner, w_last_nxt;

  logic                    w_accept;
  logic                    w_end;
  logic                    w_rearb;
  logic [N_REQ-1:0]        w_excl;
  logic [N_REQ-1:0]        w_cand;
  logic                    w_found;
  logic [IDX_W-1:0]        w_pick;

  logic signed [DATA_WIDTH-1:0] w_a, w_b;
  logic signed [PW-1:0]         w_prod;
  logic [DATA_WIDTH-1:0]        w_res;

  logic [N_REQ-1:0]        r_ptag  [LATENCY];
  logic [DATA_WIDTH-1:0]   r_pdata [LATENCY];
  logic                    w_pipe_busy;

  // While owning, r_last_owner is the current owner's index.
  assign w_accept = (r_state == S_OWN) && op_valid[r_last_owner];
  assign w_end    = w_accept && op_last[r_last_owner];

  // Round-robin pick starting after the last owner; the ending owner only wins if alone.
  always_comb begin : arb
    int unsigned j;
    w_excl  = req & ~(N_REQ'(1) << r_last_owner);
    w_cand  = ((r_state == S_OWN) && (w_excl != '0)) ? w_excl : req;
    w_found = 1'b0;
    w_pick  = r_last_owner;
    j       = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      j = (32'(r_last_owner) + i) % N_REQ;
      if (!w_found && w_cand[IDX_W'(j)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin : fsm
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_owner;
    w_rearb     = 1'b0;
    unique case (r_state)
      S_IDLE:  w_rearb = 1'b1;
      S_OWN:   w_rearb = w_end || !req[r_last_owner];
      default: w_rearb = 1'b1;
    endcase
    if (w_rearb) begin
      if (w_found) begin
        w_state_nxt = S_OWN;
        w_grant_nxt = N_REQ'(1) << w_pick;
        w_last_nxt  = w_pick;
      end else begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin : state_reg
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  // Owner operand mux and dequantized, truncated product.
  assign w_a    = op_a[32'(r_last_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign w_b    = op_b[32'(r_last_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign w_prod = PW'(w_a) * PW'(w_b);
  assign w_res  = DATA_WIDTH'(w_prod >>> FRAC_BITS);

  always_ff @(posedge clock or posedge reset) begin : pipe
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_ptag[i]  <= '0;
        r_pdata[i] <= '0;
      end
    end else begin
      r_ptag[0]  <= w_accept ? r_grant : '0;
      r_pdata[0] <= w_accept ? w_res : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_ptag[i]  <= r_ptag[i-1];
        r_pdata[i] <= r_pdata[i-1];
      end
    end
  end

  always_comb begin : busy_or
    w_pipe_busy = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_pipe_busy = w_pipe_busy | (|r_ptag[i]);
    end
  end

  assign grant     = r_grant;
  assign res_valid = r_ptag[LATENCY-1];
  assign res_data  = r_pdata[LATENCY-1];
  assign busy      = (|r_grant) | w_pipe_busy;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: arithmetic vector table plus hand-written
// arbitration, isolation, abort and reset sequences checked against an expected-result queue.
module tb_mult_share_arbiter;

  localparam int unsigned N   = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0, op_valid = '0, op_last = '0;
  logic [N*DW-1:0]   op_a = '0, op_b = '0;
  logic [N-1:0]      grant, res_valid;
  logic [DW-1:0]     res_data;
  logic              busy;

  mult_share_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .FRAC_BITS(10), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .op_valid(op_valid), .op_last(op_last),
    .op_a(op_a), .op_b(op_b), .grant(grant), .res_valid(res_valid),
    .res_data(res_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    logic [N-1:0] tag;
    logic [DW-1:0] data;
  } rec_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  rec_t mon_q[$];
  rec_t exp_q[$];
  vec_t vt[9];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (res_valid != '0) mon_q.push_back('{cyc, res_valid, res_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one operand pair for requester k this cycle; optionally expect its result.
  task automatic issue(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic last, input logic [DW-1:0] exp, input logic push);
    op_valid[k]       = 1'b1;
    op_last[k]        = last;
    op_a[k*DW +: DW]  = a;
    op_b[k*DW +: DW]  = b;
    if (push) exp_q.push_back('{cyc + LAT, N'(1) << k, exp});
    tick();
    op_valid[k] = 1'b0;
    op_last[k]  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_results(input string name);
    chk({name, " count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < mon_q.size()) begin
        chk({name, " cycle"}, 64'(mon_q[i].cyc), 64'(exp_q[i].cyc));
        chk({name, " tag"},   64'(mon_q[i].tag), 64'(exp_q[i].tag));
        chk({name, " data"},  64'(mon_q[i].data), 64'(exp_q[i].data));
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input string name);
    reset    = 1'b1;
    req      = '0;
    op_valid = '0;
    op_last  = '0;
    #1;
    chk({name, " grant"},     64'(grant), 64'(0));
    chk({name, " res_valid"}, 64'(res_valid), 64'(0));
    chk({name, " res_data"},  64'(res_data), 64'(0));
    chk({name, " busy"},      64'(busy), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vt[0] = '{32'd1024,      32'd2048,      32'd2048};
    vt[1] = '{32'(-3072),    32'd1536,      32'(-4608)};
    vt[2] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'hFFC00000};
    vt[3] = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF};
    vt[4] = '{32'h80000000,  32'h80000000,  32'h00000000};
    vt[5] = '{32'd5,         32'd7,         32'd0};
    vt[6] = '{32'(-5),       32'd7,         32'hFFFFFFFF};
    vt[7] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  32'hFFE00000};
    vt[8] = '{32'd3000,      32'(-2000),    32'hFFFFE91C};

    #3;
    do_reset("reset0");

    // Single requester burst on index 2, released together with the last op.
    req = 5'b00100;
    tick();
    chk("t1 grant", 64'(grant), 64'(5'b00100));
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) req = '0;
      issue(2, 32'(k * 1024), 32'd2048, k == 4, 32'(k * 2048), 1'b1);
    end
    chk("t1 grant released", 64'(grant), 64'(0));
    chk("t1 busy inflight", 64'(busy), 64'(1));
    drain(LAT + 2);
    check_results("t1");
    chk("t1 busy idle", 64'(busy), 64'(0));

    // Arithmetic vectors through requester 0, back to back.
    req = 5'b00001;
    tick();
    chk("t3 grant", 64'(grant), 64'(5'b00001));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) req = '0;
      issue(0, vt[i].a, vt[i].b, i == 8, vt[i].exp, 1'b1);
    end
    chk("t3 grant released", 64'(grant), 64'(0));
    drain(LAT + 2);
    check_results("t3");

    // Round robin with every requester asking and 1-op bursts.
    do_reset("reset1");
    req = 5'b11111;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t2 rr grant", 64'(grant), 64'(N'(1) << (i % 5)));
      if (i == 5) req = '0;
      issue(i % 5, 32'((i + 1) * 1024), 32'd3072, 1'b1, 32'((i + 1) * 3072), 1'b1);
    end
    chk("t2 grant released", 64'(grant), 64'(0));
    drain(LAT + 2);
    check_results("t2");

    // Requester 3 hammers op_valid while 1 owns; 3 follows 1 with no gap.
    req = 5'b01010;
    op_valid[3] = 1'b1;
    op_a[3*DW +: DW] = 32'd5120;
    op_b[3*DW +: DW] = 32'(-2048);
    tick();
    chk("t4 grant owner1", 64'(grant), 64'(5'b00010));
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) req[1] = 1'b0;
      issue(1, 32'(k * 1024), 32'd1024, k == 3, 32'(k * 1024), 1'b1);
    end
    chk("t4 grant owner3", 64'(grant), 64'(5'b01000));
    op_last[3] = 1'b1;
    req[3] = 1'b0;
    exp_q.push_back('{cyc + LAT, 5'b01000, 32'(-10240)});
    tick();
    op_valid[3] = 1'b0;
    op_last[3] = 1'b0;
    chk("t4 grant released", 64'(grant), 64'(0));
    drain(LAT + 2);
    check_results("t4");

    // Owner 0 aborts after two ops; requester 2 takes over on the next edge.
    req = 5'b00101;
    tick();
    chk("t5 grant owner0", 64'(grant), 64'(5'b00001));
    issue(0, 32'd1024, 32'd4096, 1'b0, 32'd4096, 1'b1);
    issue(0, 32'd2048, 32'd4096, 1'b0, 32'd8192, 1'b1);
    req[0] = 1'b0;
    tick();
    chk("t5 grant moved", 64'(grant), 64'(5'b00100));
    req[2] = 1'b0;
    issue(2, 32'd7168, 32'd1024, 1'b1, 32'd7168, 1'b1);
    chk("t5 grant released", 64'(grant), 64'(0));
    drain(LAT + 2);
    check_results("t5");

    // Reset with three ops in flight: nothing may emerge afterwards.
    req = 5'b00010;
    tick();
    chk("t6 grant owner1", 64'(grant), 64'(5'b00010));
    for (int k = 1; k <= 3; k++) issue(1, 32'(k * 1024), 32'd1024, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    req = 5'b10100;
    #1;
    chk("t6 rst grant", 64'(grant), 64'(0));
    chk("t6 rst res_valid", 64'(res_valid), 64'(0));
    chk("t6 rst res_data", 64'(res_data), 64'(0));
    chk("t6 rst busy", 64'(busy), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t6 first grant", 64'(grant), 64'(5'b00100));
    req = '0;
    tick();
    chk("t6 grant released", 64'(grant), 64'(0));
    drain(LAT + 3);
    check_results("t6");
    chk("t6 busy idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
